// File: rtl/seg7_capture.sv
// Captures a multiplexed two-digit active-low 7-segment display into a valid/ready pair stream.
// Optional sticky overrun flag when SEG7_CAP_OVERRUN_EN is defined. STABLE_CYCLES legal range 2..255.
`timescale 1ns/1ps

module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [1:0] Anode_Activate,
  input  logic       out_ready,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] digit_err,
  output logic       out_valid
`ifdef SEG7_CAP_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CntCap  = 8'(STABLE_CYCLES - 2);

  typedef enum logic [0:0] {
    StCollect,
    StPresent
  } state_e;

  // Returns {err, value}; unknown patterns decode to 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'b1_0000;
    case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

  logic [6:0] r_prev_seg;
  logic [1:0] r_prev_an;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  logic       w_legal;
  logic       w_match;
  logic       w_cap;
  logic       w_cap0;
  logic       w_cap1;
  logic [4:0] w_dec;

  logic [3:0] r_pend0;
  logic [3:0] r_pend1;
  logic       r_perr0;
  logic       r_perr1;
  logic       r_got0;
  logic       r_got1;

  logic [3:0] r_digit0;
  logic [3:0] r_digit1;
  logic [1:0] r_err;

  state_e     r_state;
  state_e     w_state_nxt;
  logic       w_load;

  // Stability counter and capture strobe.
  always_comb begin
    w_legal   = (Anode_Activate == 2'b10) || (Anode_Activate == 2'b01);
    w_match   = (seg == r_prev_seg) && (Anode_Activate == r_prev_an);
    w_cnt_nxt = 8'd0;
    if (w_legal && w_match) begin
      w_cnt_nxt = (r_cnt == CntLast) ? r_cnt : r_cnt + 8'd1;
    end
    w_cap  = w_legal && w_match && (r_cnt == CntCap);
    w_cap0 = w_cap && (Anode_Activate == 2'b10);
    w_cap1 = w_cap && (Anode_Activate == 2'b01);
    w_dec  = decode(seg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_seg <= 7'h7F;
      r_prev_an  <= 2'b11;
      r_cnt      <= 8'd0;
    end else begin
      r_prev_seg <= seg;
      r_prev_an  <= Anode_Activate;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Pair delivery FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      StCollect: begin
        if (r_got0 && r_got1) begin
          w_load      = 1'b1;
          w_state_nxt = StPresent;
        end
      end
      StPresent: begin
        if (out_ready) begin
          if (r_got0 && r_got1) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = StCollect;
          end
        end
      end
      default: w_state_nxt = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StCollect;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A capture on the load edge belongs to the next pair, so it wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend0 <= 4'd0;
      r_pend1 <= 4'd0;
      r_perr0 <= 1'b0;
      r_perr1 <= 1'b0;
      r_got0  <= 1'b0;
      r_got1  <= 1'b0;
    end else begin
      if (w_load) begin
        r_got0 <= 1'b0;
        r_got1 <= 1'b0;
      end
      if (w_cap0) begin
        r_pend0 <= w_dec[3:0];
        r_perr0 <= w_dec[4];
        r_got0  <= 1'b1;
      end
      if (w_cap1) begin
        r_pend1 <= w_dec[3:0];
        r_perr1 <= w_dec[4];
        r_got1  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit0 <= 4'd0;
      r_digit1 <= 4'd0;
      r_err    <= 2'b00;
    end else if (w_load) begin
      r_digit0 <= r_pend0;
      r_digit1 <= r_pend1;
      r_err    <= {r_perr1, r_perr0};
    end
  end

  assign digit0    = r_digit0;
  assign digit1    = r_digit1;
  assign digit_err = r_err;
  assign out_valid = (r_state == StPresent);

`ifdef SEG7_CAP_OVERRUN_EN
  logic r_overrun;
  logic w_ovr_set;

  // A capture on a load edge replaces data that was just delivered, so it is not an overrun.
  always_comb begin
    w_ovr_set = (r_state == StPresent) && !w_load &&
                ((w_cap0 && r_got0) || (w_cap1 && r_got1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

`ifndef SYNTHESIS
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable({digit0, digit1, digit_err})));
  a_one_hot_cap : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_cap0 && w_cap1));
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: table-driven pair sweep plus hand-written corner sequences.
// Expected pairs go into a scoreboard queue when driven and are compared when the DUT presents them.
`timescale 1ns/1ps

module tb_seg7_capture;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [1:0] Anode_Activate;
  logic       out_ready;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] digit_err;
  logic       out_valid;
`ifdef SEG7_CAP_OVERRUN_EN
  logic       overrun;
`endif

  seg7_capture #(
    .STABLE_CYCLES(N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg           (seg),
    .Anode_Activate(Anode_Activate),
    .out_ready     (out_ready),
    .digit0        (digit0),
    .digit1        (digit1),
    .digit_err     (digit_err),
    .out_valid     (out_valid)
`ifdef SEG7_CAP_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] s0;
    logic [6:0] s1;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] err;
  } vec_t;

  typedef struct {
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] err;
  } exp_t;

  vec_t       vecs[18];
  exp_t       sb[$];
  logic [6:0] pats[16];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] a, input logic [6:0] s, input int n);
    Anode_Activate = a;
    seg            = s;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle();
    Anode_Activate = 2'b11;
    seg            = 7'h7F;
  endtask

  task automatic send_pair(input logic [6:0] s0, input logic [6:0] s1);
    hold(2'b10, s0, N);
    hold(2'b01, s1, N);
    idle();
  endtask

  task automatic push_exp(input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] err);
    exp_t e;
    e.d0  = d0;
    e.d1  = d1;
    e.err = err;
    sb.push_back(e);
  endtask

  // Compares presented outputs against the oldest outstanding expected pair.
  task automatic chk_out(input string name);
    exp_t e;
    chk({name, "_valid"}, int'(out_valid), 1);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb[0];
      chk({name, "_d0"}, int'(digit0), int'(e.d0));
      chk({name, "_d1"}, int'(digit1), int'(e.d1));
      chk({name, "_err"}, int'(digit_err), int'(e.err));
    end
  endtask

  task automatic pop_exp();
    exp_t e;
    if (sb.size() != 0) e = sb.pop_front();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    pop_exp();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_d0", int'(digit0), 0);
    chk("rst_d1", int'(digit1), 0);
    chk("rst_err", int'(digit_err), 0);
`ifdef SEG7_CAP_OVERRUN_EN
    chk("rst_overrun", int'(overrun), 0);
`endif
    step();
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 16; i++) begin
      vecs[i].s0  = pats[i];
      vecs[i].s1  = pats[15-i];
      vecs[i].d0  = 4'(i);
      vecs[i].d1  = 4'(15 - i);
      vecs[i].err = 2'b00;
    end
    vecs[16] = '{s0: 7'h7F, s1: 7'h0E, d0: 4'h0, d1: 4'hF, err: 2'b01};
    vecs[17] = '{s0: 7'h0E, s1: 7'h5A, d0: 4'hF, d1: 4'h0, err: 2'b10};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    do_reset();
    step();

    // Basic pair with exact one-cycle latency after the second capture.
    send_pair(7'h24, 7'h79);
    push_exp(4'h2, 4'h1, 2'b00);
    chk("lat_early", int'(out_valid), 0);
    step();
    chk_out("basic");
    accept();
    chk("basic_drop", int'(out_valid), 0);
    chk("basic_hold_d0", int'(digit0), 2);

    // Table sweep, including undecodable patterns on each digit.
    for (int v = 0; v < 18; v++) begin
      send_pair(vecs[v].s0, vecs[v].s1);
      push_exp(vecs[v].d0, vecs[v].d1, vecs[v].err);
      chk($sformatf("v%0d_early", v), int'(out_valid), 0);
      step();
      chk_out($sformatf("v%0d", v));
      step();
      chk($sformatf("v%0d_stall", v), int'(out_valid), 1);
      accept();
      chk($sformatf("v%0d_drop", v), int'(out_valid), 0);
      chk($sformatf("v%0d_keep_d1", v), int'(digit1), int'(vecs[v].d1));
    end

    // Dwells one sample short never capture.
    do_reset();
    for (int k = 0; k < 8; k++) hold(2'b10, (k % 2 == 0) ? 7'h40 : 7'h79, N - 1);
    hold(2'b01, 7'h30, N);
    idle();
    step();
    step();
    chk("short_dwell", int'(out_valid), 0);

    // Reset after a digit0 capture discards it.
    do_reset();
    hold(2'b10, 7'h24, N);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    hold(2'b01, 7'h79, N);
    idle();
    step();
    step();
    chk("rst_discard", int'(out_valid), 0);

    // Reset while presenting drops the pair without a handshake.
    do_reset();
    send_pair(7'h24, 7'h79);
    push_exp(4'h2, 4'h1, 2'b00);
    step();
    chk_out("pre_rst");
    rst_n = 1'b0;
    #2;
    chk("present_rst_valid", int'(out_valid), 0);
    chk("present_rst_d0", int'(digit0), 0);
    step();
    rst_n = 1'b1;
    sb.delete();
    step();
    step();
    chk("present_rst_after", int'(out_valid), 0);

    // A long dwell captures only once.
    do_reset();
    hold(2'b10, 7'h40, N);
    hold(2'b01, 7'h79, 3 * N);
    idle();
    push_exp(4'h0, 4'h1, 2'b00);
    chk_out("long_dwell");
    accept();
    hold(2'b10, 7'h24, N);
    idle();
    step();
    step();
    chk("single_capture", int'(out_valid), 0);

    // Stalled consumer: newest pending data wins, then back-to-back delivery.
    do_reset();
    send_pair(7'h30, 7'h19);
    push_exp(4'h3, 4'h4, 2'b00);
    step();
    chk_out("p34");
    send_pair(7'h12, 7'h02);
    step();
    chk_out("stall1");
    send_pair(7'h78, 7'h00);
    push_exp(4'h7, 4'h8, 2'b00);
    step();
    chk_out("stall2");
`ifdef SEG7_CAP_OVERRUN_EN
    chk("overrun", int'(overrun), 1);
`endif
    out_ready = 1'b1;
    step();
    pop_exp();
    chk_out("b2b");
    step();
    pop_exp();
    out_ready = 1'b0;
    chk("b2b_drop", int'(out_valid), 0);
    chk("b2b_keep_d0", int'(digit0), 7);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 clk  input  1  single clock; all inputs are synchronous to its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 seg  input  7  segment bus {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-005 Anode_Activate  input  2  digit select, active-low: 2'b10 = digit0 lit, 2'b01 = digit1 lit, 2'b11/2'b00 = no legal digit.
REQ-006 digit0  output  4  decoded value of digit0 from the last delivered pair.
REQ-007 digit1  output  4  decoded value of digit1 from the last delivered pair.
REQ-008 digit_err  output  2  bit n set when digitn's captured pattern was not in the decode table.
REQ-009 out_valid  output  1  digit0/digit1/digit_err hold a pair not yet accepted.
REQ-010 out_ready  input  1  consumer accepts the pair when out_valid and out_ready are both high at a rising edge.
REQ-011 overrun  output  1  sticky; present only when SEG7_CAP_OVERRUN_EN is defined.

Function
REQ-012 Decode table (seg hex -> value): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F; any other pattern decodes to 0 and sets the digit's error bit.
REQ-013 Stability counter: a sample matches when seg and Anode_Activate both equal their previous-cycle values; any mismatch clears the counter to 0.
REQ-014 The counter holds 0 while Anode_Activate is 2'b11 or 2'b00.
REQ-015 A capture happens on the edge where the counter reaches STABLE_CYCLES-1 (the STABLE_CYCLES-th identical sample); exactly one capture per dwell; the counter saturates until the next change.
REQ-016 A capture loads the selected digit's value and error bit into a pending register and sets that digit's got flag; a recapture of the same digit before pairing overwrites it.
REQ-017 States: COLLECT (waiting for both got flags) and PRESENT (out_valid high).
REQ-018 COLLECT -> PRESENT on the edge after both got flags are set: outputs load from pending, got flags clear, out_valid rises; total latency is 1 cycle after the second capture.
REQ-019 PRESENT -> COLLECT on an edge with out_ready high; outputs hold their values and out_valid falls.
REQ-020 Capture continues in PRESENT; outputs stay stable while out_valid is high.
REQ-021 If both got flags are set in PRESENT and the handshake completes on the same edge, the new pair loads and out_valid stays high (back-to-back delivery).
REQ-022 If both got flags are set in PRESENT without a handshake, the pending pair waits; any further capture overwrites its digit (newest data wins).

Reset
REQ-023 With rst_n low: digit0=0, digit1=0, digit_err=0, out_valid=0, overrun=0, counter=0, got flags clear, previous-sample registers = 7'h7F / 2'b11, state=COLLECT.
REQ-024 Reset asserted mid-dwell or in PRESENT discards all partial and pending data with no handshake; capture restarts from an empty counter after release.

Configuration
REQ-025 SEG7_CAP_OVERRUN_EN defined: the overrun port exists and sets when a capture overwrites a digit whose got flag is set while in PRESENT; it clears only on reset.
REQ-026 SEG7_CAP_OVERRUN_EN undefined: no overrun port or logic; overwrites are silent.

Verification
REQ-027 Hold Anode=2'b10, seg=7'h24 for 4 cycles, then Anode=2'b01, seg=7'h79 for 4 cycles -> out_valid=1 one cycle after the second capture with digit0=2, digit1=1, digit_err=0.
REQ-028 Toggle seg every 3 cycles with STABLE_CYCLES=4 -> no capture and out_valid stays 0.
REQ-029 Present digit0 seg=7'h7F, then digit1 seg=7'h0E -> digit_err=2'b01, digit0=0, digit1=F.
REQ-030 Hold out_ready=0, deliver pair (3,4), then pair (5,6), then pair (7,8) -> outputs stay 3,4; with the macro, overrun=1; after out_ready=1, outputs show 7,8 on the next edge.
REQ-031 Drop rst_n for one cycle after a digit0 capture, then present digit1 only -> out_valid stays 0.
REQ-032 Sweep all 16 table patterns on both digits through repeated pairs -> each delivered value equals its table entry.
